// File: rtl/button_ctrl.sv
// ---------------------------------------------------------------------------
// button_ctrl
// Debounces one raw, bouncing, active-low push-button and turns accepted
// presses into events.
//  - A short press increments a 3-digit BCD counter and rotates a one-hot
//    LED marker.
//  - A long press clears the counter.
//  - With AUTOREPEAT_EN defined, a long press instead increments the counter
//    and keeps incrementing every REPEAT_CYCLES while the key stays down.
// The counter, a 'P' (pressed) glyph and an 'L' (long) glyph are driven onto
// registered seven-segment outputs.
//
// Optional feature macro: AUTOREPEAT_EN
//
// Parameters
//   DB_CYCLES      consecutive stable cycles needed to accept a press/release
//   LONG_CYCLES    cycles from HELD entry until the long-press event
//   REPEAT_CYCLES  auto-repeat interval (AUTOREPEAT_EN builds only)
//   SEG_ACTIVE_LOW 1: segment/dp bits active-low, 0: active-high
//
// Ports
//   clk     in   system clock
//   rst     in   synchronous reset, active-high
//   btn_n   in   raw key, active-low, asynchronous to clk
//   sthex0  out  ones digit, [6:0]=g..a, [7]=dp (always off)
//   sthex1  out  tens digit
//   sthex2  out  hundreds digit
//   sthex3  out  always blank
//   sthex4  out  'P' while the debounced key is pressed, else blank
//   sthex5  out  'L' once the long press is reached in this hold, else blank
//   stled   out  one-hot marker, rotates left on every count increment
// ---------------------------------------------------------------------------
module button_ctrl #(
   parameter int unsigned DB_CYCLES      = 500000,
   parameter int unsigned LONG_CYCLES    = 50000000,
   parameter int unsigned REPEAT_CYCLES  = 10000000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_n,
   output logic [7:0]  sthex0,
   output logic [7:0]  sthex1,
   output logic [7:0]  sthex2,
   output logic [7:0]  sthex3,
   output logic [7:0]  sthex4,
   output logic [7:0]  sthex5,
   output logic [15:0] stled
);

   localparam int          STAB_W   = $clog2(DB_CYCLES + 1);
   localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int          HOLD_W   = $clog2(HOLD_MAX + 1);

   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] LONG_VAL  = HOLD_W'(LONG_CYCLES);

   // Glyph codes are stored active-low; XOR with the polarity mask flips them
   // for active-high boards.
   localparam logic [7:0] SEG_POL   = SEG_ACTIVE_LOW ? 8'h00 : 8'hFF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_P     = 8'h8C;
   localparam logic [7:0] SEG_L     = 8'hC7;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      REL_WAIT
   } StateT;

   StateT              r_state;
   StateT              w_nextState;
   logic [1:0]         r_sync;
   logic               w_btnS;
   logic [STAB_W-1:0]  r_stab;
   logic [STAB_W-1:0]  w_stabNext;
   logic [HOLD_W-1:0]  r_hold;
   logic               r_long;
   logic               w_relAccept;
   logic               w_active;
   logic               w_longEvt;
   logic               w_incr;
   logic               w_clear;
   logic [3:0]         r_digit0;
   logic [3:0]         r_digit1;
   logic [3:0]         r_digit2;
   logic [15:0]        r_led;
   logic [7:0]         r_hex0;
   logic [7:0]         r_hex1;
   logic [7:0]         r_hex2;
   logic [7:0]         r_hex3;
   logic [7:0]         r_hex4;
   logic [7:0]         r_hex5;

   function automatic logic [7:0] segCode(input logic [3:0] digit);
      logic [7:0] code;
      case (digit)
         4'd0:    code = 8'hC0;
         4'd1:    code = 8'hF9;
         4'd2:    code = 8'hA4;
         4'd3:    code = 8'hB0;
         4'd4:    code = 8'h99;
         4'd5:    code = 8'h92;
         4'd6:    code = 8'h82;
         4'd7:    code = 8'hF8;
         4'd8:    code = 8'h80;
         4'd9:    code = 8'h90;
         default: code = SEG_BLANK;
      endcase
      return code ^ SEG_POL;
   endfunction

   // Two-flop synchroniser; the key is inverted here so everything
   // downstream sees active-high "pressed".
   always_ff @(posedge clk) begin
      if (rst) r_sync <= 2'b00;
      else     r_sync <= {r_sync[0], ~btn_n};
   end

   assign w_btnS   = r_sync[1];
   assign w_active = (r_state == HELD) || (r_state == REL_WAIT);

   // State and stability-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_stab  <= '0;
      end else begin
         r_state <= w_nextState;
         r_stab  <= w_stabNext;
      end
   end

   // Next-state logic. The stability counter only advances while a wait
   // state keeps seeing the level it waits for; any other case (mismatch,
   // transition, non-wait state) returns it to zero.
   always_comb begin
      w_nextState = r_state;
      w_stabNext  = '0;
      w_relAccept = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_btnS) w_nextState = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!w_btnS)                  w_nextState = IDLE;
            else if (r_stab == STAB_LAST) w_nextState = HELD;
            else                          w_stabNext  = r_stab + 1'b1;
         end
         HELD: begin
            if (!w_btnS) w_nextState = REL_WAIT;
         end
         REL_WAIT: begin
            if (w_btnS) begin
               w_nextState = HELD;
            end else if (r_stab == STAB_LAST) begin
               w_nextState = IDLE;
               w_relAccept = 1'b1;
            end else begin
               w_stabNext = r_stab + 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Hold counter: zero outside a debounced hold, so the first HELD cycle
   // reads 0. It saturates at LONG_VAL, and r_long stops a second event.
   always_ff @(posedge clk) begin
      if (rst)                    r_hold <= '0;
      else if (!w_active)         r_hold <= '0;
      else if (r_hold != LONG_VAL) r_hold <= r_hold + 1'b1;
   end

   assign w_longEvt = w_active && !r_long && (r_hold == LONG_VAL) && !w_relAccept;

   // The long flag lives until the release that ends this hold is accepted.
   always_ff @(posedge clk) begin
      if (rst)              r_long <= 1'b0;
      else if (w_relAccept) r_long <= 1'b0;
      else if (w_longEvt)   r_long <= 1'b1;
   end

`ifdef AUTOREPEAT_EN
   localparam logic [HOLD_W-1:0] REP_LAST = HOLD_W'(REPEAT_CYCLES - 1);

   logic [HOLD_W-1:0] r_rep;
   logic              w_repEvt;

   // Repeat timer starts at zero on the cycle after the long event and fires
   // every REPEAT_CYCLES cycles after that while the key is still held.
   always_ff @(posedge clk) begin
      if (rst)                                r_rep <= '0;
      else if (!w_active || !r_long || w_repEvt) r_rep <= '0;
      else                                    r_rep <= r_rep + 1'b1;
   end

   assign w_repEvt = w_active && r_long && (r_rep == REP_LAST) && !w_relAccept;
   assign w_incr   = (w_relAccept && !r_long) || w_longEvt || w_repEvt;
   assign w_clear  = 1'b0;
`else
   assign w_incr  = w_relAccept && !r_long;
   assign w_clear = w_longEvt;
`endif

   // BCD press counter and LED marker. A clear leaves the marker in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_digit0 <= 4'd0;
         r_digit1 <= 4'd0;
         r_digit2 <= 4'd0;
         r_led    <= 16'h0001;
      end else if (w_clear) begin
         r_digit0 <= 4'd0;
         r_digit1 <= 4'd0;
         r_digit2 <= 4'd0;
      end else if (w_incr) begin
         r_led <= {r_led[14:0], r_led[15]};
         if (r_digit0 == 4'd9) begin
            r_digit0 <= 4'd0;
            if (r_digit1 == 4'd9) begin
               r_digit1 <= 4'd0;
               r_digit2 <= (r_digit2 == 4'd9) ? 4'd0 : r_digit2 + 4'd1;
            end else begin
               r_digit1 <= r_digit1 + 4'd1;
            end
         end else begin
            r_digit0 <= r_digit0 + 4'd1;
         end
      end
   end

   // Display registers: one extra cycle after count/flag updates, giving
   // clean, glitch-free segment drives.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hex0 <= segCode(4'd0);
         r_hex1 <= segCode(4'd0);
         r_hex2 <= segCode(4'd0);
         r_hex3 <= SEG_BLANK ^ SEG_POL;
         r_hex4 <= SEG_BLANK ^ SEG_POL;
         r_hex5 <= SEG_BLANK ^ SEG_POL;
      end else begin
         r_hex0 <= segCode(r_digit0);
         r_hex1 <= segCode(r_digit1);
         r_hex2 <= segCode(r_digit2);
         r_hex3 <= SEG_BLANK ^ SEG_POL;
         r_hex4 <= (w_active ? SEG_P : SEG_BLANK) ^ SEG_POL;
         r_hex5 <= (r_long ? SEG_L : SEG_BLANK) ^ SEG_POL;
      end
   end

   assign sthex0 = r_hex0;
   assign sthex1 = r_hex1;
   assign sthex2 = r_hex2;
   assign sthex3 = r_hex3;
   assign sthex4 = r_hex4;
   assign sthex5 = r_hex5;
   assign stled  = r_led;

endmodule

// File: tb/tb_button_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_ctrl
// Directed bench for button_ctrl with small timing parameters
// (DB=4, LONG=20, REPEAT=8, active-low segments). Expected values are
// hand-computed constants. Inputs change and outputs are sampled 1 time
// unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_button_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        btn_n = 1'b1;
   logic [7:0]  sthex0;
   logic [7:0]  sthex1;
   logic [7:0]  sthex2;
   logic [7:0]  sthex3;
   logic [7:0]  sthex4;
   logic [7:0]  sthex5;
   logic [15:0] stled;

   int testCount = 0;
   int failCount = 0;

   button_ctrl #(
      .DB_CYCLES(4),
      .LONG_CYCLES(20),
      .REPEAT_CYCLES(8),
      .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_n(btn_n),
      .sthex0(sthex0),
      .sthex1(sthex1),
      .sthex2(sthex2),
      .sthex3(sthex3),
      .sthex4(sthex4),
      .sthex5(sthex5),
      .stled(stled)
   );

   always #5 clk = ~clk;

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the key at one level for a number of clock edges.
   task automatic applyStimulus(input logic level, input int cycles);
      btn_n = level;
      waitCycles(cycles);
   endtask

   task automatic pressShort();
      applyStimulus(1'b0, 10);
      applyStimulus(1'b1, 10);
   endtask

   task automatic doReset();
      rst = 1'b1;
      waitCycles(3);
      rst = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      // Reset state
      btn_n = 1'b1;
      doReset();
      checkOutput("rst_hex0", {8'h00, sthex0}, 16'h00C0);
      checkOutput("rst_hex1", {8'h00, sthex1}, 16'h00C0);
      checkOutput("rst_hex2", {8'h00, sthex2}, 16'h00C0);
      checkOutput("rst_hex3", {8'h00, sthex3}, 16'h00FF);
      checkOutput("rst_hex4", {8'h00, sthex4}, 16'h00FF);
      checkOutput("rst_hex5", {8'h00, sthex5}, 16'h00FF);
      checkOutput("rst_led",  stled,           16'h0001);

      // One clean short press
      applyStimulus(1'b0, 10);
      checkOutput("press_p",     {8'h00, sthex4}, 16'h008C);
      checkOutput("press_nocnt", {8'h00, sthex0}, 16'h00C0);
      applyStimulus(1'b1, 10);
      checkOutput("short_hex0", {8'h00, sthex0}, 16'h00F9);
      checkOutput("short_hex1", {8'h00, sthex1}, 16'h00C0);
      checkOutput("short_led",  stled,           16'h0002);
      checkOutput("short_p",    {8'h00, sthex4}, 16'h00FF);

      // Bounce pulses shorter than the debounce window
      applyStimulus(1'b0, 1);
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, 2);
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, 3);
      applyStimulus(1'b1, 8);
      checkOutput("bounce_hex0", {8'h00, sthex0}, 16'h00F9);
      checkOutput("bounce_p",    {8'h00, sthex4}, 16'h00FF);
      checkOutput("bounce_led",  stled,           16'h0002);

      // Hold with a 3-cycle release glitch in the middle counts once
      applyStimulus(1'b0, 8);
      applyStimulus(1'b1, 3);
      applyStimulus(1'b0, 7);
      checkOutput("glitch_held", {8'h00, sthex0}, 16'h00F9);
      applyStimulus(1'b1, 10);
      checkOutput("glitch_hex0", {8'h00, sthex0}, 16'h00A4);
      checkOutput("glitch_led",  stled,           16'h0004);

      // 1000 short presses wrap the counter back to 000
      doReset();
      for (int i = 0; i < 1000; i++) begin
         pressShort();
         if (i == 122) begin
            checkOutput("c123_hex0", {8'h00, sthex0}, 16'h00B0);
            checkOutput("c123_hex1", {8'h00, sthex1}, 16'h00A4);
            checkOutput("c123_hex2", {8'h00, sthex2}, 16'h00F9);
            checkOutput("c123_led",  stled,           16'h0800);
         end
      end
      checkOutput("wrap_hex0", {8'h00, sthex0}, 16'h00C0);
      checkOutput("wrap_hex1", {8'h00, sthex1}, 16'h00C0);
      checkOutput("wrap_hex2", {8'h00, sthex2}, 16'h00C0);
      checkOutput("wrap_led",  stled,           16'h0100);

`ifndef AUTOREPEAT_EN
      // Long press clears the count without moving the marker
      doReset();
      repeat (5) pressShort();
      checkOutput("five_hex0", {8'h00, sthex0}, 16'h0092);
      checkOutput("five_led",  stled,           16'h0020);
      applyStimulus(1'b0, 30);
      checkOutput("long_hex0", {8'h00, sthex0}, 16'h00C0);
      checkOutput("long_l",    {8'h00, sthex5}, 16'h00C7);
      checkOutput("long_p",    {8'h00, sthex4}, 16'h008C);
      checkOutput("long_led",  stled,           16'h0020);
      applyStimulus(1'b1, 10);
      checkOutput("longrel_hex0", {8'h00, sthex0}, 16'h00C0);
      checkOutput("longrel_l",    {8'h00, sthex5}, 16'h00FF);
      checkOutput("longrel_led",  stled,           16'h0020);
`else
      // Auto-repeat: long event at 20, repeats at 28, 36 and (during release) 44
      doReset();
      applyStimulus(1'b0, 48);
      checkOutput("rep_hex0", {8'h00, sthex0}, 16'h00B0);
      checkOutput("rep_l",    {8'h00, sthex5}, 16'h00C7);
      checkOutput("rep_led",  stled,           16'h0008);
      applyStimulus(1'b1, 12);
      checkOutput("reprel_hex0", {8'h00, sthex0}, 16'h0099);
      checkOutput("reprel_l",    {8'h00, sthex5}, 16'h00FF);
      checkOutput("reprel_led",  stled,           16'h0010);
`endif

      // Reset while HELD, key still down afterwards is a fresh press
      applyStimulus(1'b0, 10);
      checkOutput("midrst_pre_p", {8'h00, sthex4}, 16'h008C);
      rst = 1'b1;
      waitCycles(1);
      rst = 1'b0;
      checkOutput("midrst_led",  stled,           16'h0001);
      checkOutput("midrst_p",    {8'h00, sthex4}, 16'h00FF);
      checkOutput("midrst_hex0", {8'h00, sthex0}, 16'h00C0);
      applyStimulus(1'b0, 10);
      checkOutput("midrst_held", {8'h00, sthex4}, 16'h008C);
      applyStimulus(1'b1, 10);
      checkOutput("midrst_hex0_after", {8'h00, sthex0}, 16'h00F9);
      checkOutput("midrst_led_after",  stled,           16'h0002);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
